// File: rtl/gcd_seq_pkg.sv
// gcd_seq_pkg: shared state type and sizing helpers for gcd_job_sequencer.
// Timeout logic is compiled in only with GCD_SEQ_TIMEOUT_EN.
package gcd_seq_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_DONE
  } state_t;

  localparam int GCD_WIDTH = 8;

  // run counter only needs to reach TIMEOUT_CYCLES-1
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/gcd_seq_fifo.sv
// gcd_seq_fifo: operand-pair FIFO, power-of-two depth,
// wrap-around pointers and registered occupancy.
module gcd_seq_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [2*WIDTH-1:0] wdata,
  output logic [2*WIDTH-1:0] rdata,
  output logic               full,
  output logic               empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]      wp;
  logic [AW-1:0]      rp;
  logic [AW:0]        cnt;
  logic               wr;
  logic               rd;

  assign full  = (cnt == DEPTH[AW:0]);
  assign empty = (cnt == '0);
  assign wr    = push && !full;
  assign rd    = pop && !empty;
  assign rdata = mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (rd) rp <= rp + 1'b1;
      case ({wr, rd})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/gcd_job_sequencer.sv
// gcd_job_sequencer: queues operand pairs and drives the GCD core.
// Optional RUN timeout: define GCD_SEQ_TIMEOUT_EN.
module gcd_job_sequencer
  import gcd_seq_pkg::*;
#(
  parameter int WIDTH          = GCD_WIDTH,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic             _clock,
  input  logic             _reset,
  input  logic             _in_valid,
  output logic             _in_ready,
  input  logic [WIDTH-1:0] _in_num0,
  input  logic [WIDTH-1:0] _in_num1,
  output logic             _gcd_restart,
  output logic [WIDTH-1:0] _gcd_num0,
  output logic [WIDTH-1:0] _gcd_num1,
  input  logic [WIDTH-1:0] _gcd_greatest,
  input  logic             _gcd_success,
  output logic             _out_valid,
  input  logic             _out_ready,
  output logic [WIDTH-1:0] _out_greatest,
  output logic             _out_timeout
);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_tmo
    $error("TIMEOUT_CYCLES must be positive");
  end

  state_t             state;
  state_t             nxt;
  logic [2*WIDTH-1:0] rdata;
  logic [WIDTH-1:0]   f0;
  logic [WIDTH-1:0]   f1;
  logic               full;
  logic               empty;
  logic               pop;
  logic               ld;
  logic               byp;
  logic               cap;
  logic               restart_q;

  assign {f0, f1}     = rdata;
  assign _in_ready    = !full;
  assign _out_valid   = (state == S_DONE);
  assign _gcd_restart = restart_q;

  gcd_seq_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (_clock),
    .rst_n (_reset),
    .push  (_in_valid),
    .pop   (pop),
    .wdata ({_in_num0, _in_num1}),
    .rdata (rdata),
    .full  (full),
    .empty (empty)
  );

`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int CW = cnt_width(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt;
  logic          tmo;
  logic          tmo_q;

  assign _out_timeout = tmo_q;

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) cnt <= '0;
    else if (state == S_LOAD) cnt <= '0;
    else if (state == S_RUN) cnt <= cnt + 1'b1;
  end
`else
  assign _out_timeout = 1'b0;
`endif

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) state <= S_IDLE;
    else state <= nxt;
  end

  always_comb begin
    nxt = state;
    pop = 1'b0;
    ld  = 1'b0;
    byp = 1'b0;
    cap = 1'b0;
`ifdef GCD_SEQ_TIMEOUT_EN
    tmo = 1'b0;
`endif
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          // gcd with a zero operand is just the other operand
          if (f0 == '0 || f1 == '0) begin
            byp = 1'b1;
            nxt = S_DONE;
          end else begin
            ld  = 1'b1;
            nxt = S_LOAD;
          end
        end
      end
      S_LOAD: nxt = S_RUN;
      S_RUN: begin
        if (_gcd_success) begin
          cap = 1'b1;
          nxt = S_DONE;
        end
`ifdef GCD_SEQ_TIMEOUT_EN
        else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
          tmo = 1'b1;
          nxt = S_DONE;
        end
`endif
      end
      S_DONE: begin
        if (_out_ready) nxt = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge _clock or negedge _reset) begin
    if (!_reset) begin
      restart_q     <= 1'b1;
      _gcd_num0     <= '0;
      _gcd_num1     <= '0;
      _out_greatest <= '0;
`ifdef GCD_SEQ_TIMEOUT_EN
      tmo_q         <= 1'b0;
`endif
    end else begin
      restart_q <= (nxt == S_LOAD);
      if (ld) begin
        _gcd_num0 <= f0;
        _gcd_num1 <= f1;
      end
      if (byp) _out_greatest <= f0 | f1;
      if (cap) _out_greatest <= _gcd_greatest;
`ifdef GCD_SEQ_TIMEOUT_EN
      if (byp || cap) tmo_q <= 1'b0;
      if (tmo) begin
        _out_greatest <= '0;
        tmo_q         <= 1'b1;
      end
`endif
    end
  end

endmodule
